// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for the S-Machine CPU: owns the PC, drives the
// instruction memory address and hands captured words to decode via valid/ready.
module fetch_sequencer #(
    parameter int unsigned        ADDR_W      = 8,
    parameter int unsigned        DATA_W      = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
    parameter logic [3:0]         HALT_OPCODE = 4'b1000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              halted,
    output logic [15:0]       retired_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_HOLD,
        ST_HALTED
    } state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   pc_reg;
    logic [ADDR_W-1:0]   imem_addr_reg;
    logic [DATA_W-1:0]   instr_reg;
    logic [ADDR_W-1:0]   instr_pc_reg;
    logic                instr_valid_reg;
    logic                halted_reg;
    logic [15:0]         retired_count_reg;

    logic                is_halt;
    logic                handshake;

    assign is_halt   = (instr_reg[DATA_W-1 -: 4] == HALT_OPCODE);
    assign handshake = (state_reg == ST_HOLD) && instr_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= ST_IDLE;
            pc_reg            <= RESET_PC;
            imem_addr_reg     <= RESET_PC;
            instr_reg         <= '0;
            instr_pc_reg      <= '0;
            instr_valid_reg   <= 1'b0;
            halted_reg        <= 1'b0;
            retired_count_reg <= '0;
        end else begin
            // A handshake still retires the word even when a branch wins the next state.
            if (handshake && (retired_count_reg != 16'hFFFF)) begin
                retired_count_reg <= retired_count_reg + 16'd1;
            end

            if (branch_valid && (state_reg != ST_IDLE)) begin
                pc_reg          <= branch_target;
                imem_addr_reg   <= branch_target;
                instr_valid_reg <= 1'b0;
                halted_reg      <= 1'b0;
                state_reg       <= ST_ISSUE;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (branch_valid) begin
                            pc_reg <= branch_target;
                        end else if (enable) begin
                            imem_addr_reg <= pc_reg;
                            state_reg     <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        if (enable) begin
                            state_reg <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        instr_reg       <= imem_data;
                        instr_pc_reg    <= pc_reg;
                        instr_valid_reg <= 1'b1;
                        pc_reg          <= pc_reg + 1'b1;
                        state_reg       <= ST_HOLD;
                    end
                    ST_HOLD: begin
                        if (instr_ready) begin
                            instr_valid_reg <= 1'b0;
                            if (is_halt) begin
                                halted_reg <= 1'b1;
                                state_reg  <= ST_HALTED;
                            end else begin
                                imem_addr_reg <= pc_reg;
                                state_reg     <= ST_ISSUE;
                            end
                        end
                    end
                    ST_HALTED: begin
                        state_reg <= ST_HALTED;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign imem_addr     = imem_addr_reg;
    assign instr         = instr_reg;
    assign instr_pc      = instr_pc_reg;
    assign instr_valid   = instr_valid_reg;
    assign halted        = halted_reg;
    assign retired_count = retired_count_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboarded bench for fetch_sequencer: a synchronous-read memory model feeds the DUT,
// expected (pc, word) pairs are queued as fetches are set up and checked as decode sees them.
module tb_fetch_sequencer;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] ins;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_valid;
    logic [7:0]  branch_target;
    logic        halted;
    logic [15:0] retired_count;

    logic [15:0] mem [0:255];
    exp_t        sb [$];
    int          cmp_count = 0;
    int          err_count = 0;

    fetch_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .halted        (halted),
        .retired_count (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= mem[imem_addr];

    task automatic step();
        @(negedge clk);
    endtask

    // Waits (bounded) for instr_valid; n is the number of cycles it took.
    task automatic wait_valid(output int n);
        n = 0;
        while (instr_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb.size() == 0) e = '1;
        else e = sb.pop_front();
    endtask

    task automatic test_reset();
        exp_t e;
        reset_n = 1'b0; enable = 1'b0; instr_ready = 1'b0;
        branch_valid = 1'b0; branch_target = 8'h00;
        step(); step();
        cmp_count++;
        if ({imem_addr, instr, instr_pc, instr_valid, halted, retired_count} !== 42'd0) begin
            err_count++;
            $display("FAIL reset_state: addr=%h instr=%h pc=%h v=%b h=%b cnt=%h required all zero",
                     imem_addr, instr, instr_pc, instr_valid, halted, retired_count);
        end
        reset_n = 1'b1;
        step();
        e = '0;
        cmp_count++;
        if (instr_valid !== 1'b0 || imem_addr !== 8'h00) begin
            err_count++;
            $display("FAIL idle_after_reset: v=%b addr=%h required v=0 addr=00", instr_valid, imem_addr);
        end
    endtask

    task automatic test_basic_fetch();
        exp_t e;
        int   n;
        for (int i = 0; i < 3; i++) sb.push_back({i[7:0], mem[i]});
        instr_ready = 1'b1;
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid(n);
            cmp_count++;
            if (n !== ((k == 0) ? 3 : 2)) begin
                err_count++;
                $display("FAIL basic_latency[%0d]: cycles=%0d required %0d", k, n, (k == 0) ? 3 : 2);
            end
            pop_exp(e);
            $display("txn basic pc=%h instr=%h", instr_pc, instr);
            cmp_count++;
            if (instr_pc !== e.pc || instr !== e.ins) begin
                err_count++;
                $display("FAIL basic_word[%0d]: pc=%h instr=%h required pc=%h instr=%h",
                         k, instr_pc, instr, e.pc, e.ins);
            end
            if (k == 2) enable = 1'b0;
            step();
        end
        cmp_count++;
        if (retired_count !== 16'd3 || instr_valid !== 1'b0) begin
            err_count++;
            $display("FAIL basic_count: cnt=%0d v=%b required cnt=3 v=0", retired_count, instr_valid);
        end
    endtask

    task automatic test_hold_stall();
        exp_t        e;
        int          n;
        logic [47:0] snap;
        sb.push_back({8'h03, mem[3]});
        instr_ready = 1'b0;
        enable = 1'b1;
        wait_valid(n);
        pop_exp(e);
        $display("txn stall pc=%h instr=%h", instr_pc, instr);
        cmp_count++;
        if (n !== 2 || instr_pc !== e.pc || instr !== e.ins) begin
            err_count++;
            $display("FAIL stall_word: cycles=%0d pc=%h instr=%h required 2 pc=%h instr=%h",
                     n, instr_pc, instr, e.pc, e.ins);
        end
        snap = {instr, instr_pc, imem_addr, retired_count};
        for (int c = 0; c < 5; c++) begin
            step();
            cmp_count++;
            if (instr_valid !== 1'b1 || {instr, instr_pc, imem_addr, retired_count} !== snap) begin
                err_count++;
                $display("FAIL stall_hold[%0d]: v=%b state=%h required v=1 state=%h",
                         c, instr_valid, {instr, instr_pc, imem_addr, retired_count}, snap);
            end
        end
        instr_ready = 1'b1;
        enable = 1'b0;
        step();
        cmp_count++;
        if (retired_count !== 16'd4) begin
            err_count++;
            $display("FAIL stall_count: cnt=%0d required 4", retired_count);
        end
    endtask

    task automatic test_halt();
        exp_t e;
        int   n;
        for (int i = 4; i < 8; i++) sb.push_back({i[7:0], mem[i]});
        instr_ready = 1'b1;
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid(n);
            pop_exp(e);
            $display("txn halt pc=%h instr=%h", instr_pc, instr);
            cmp_count++;
            if (n !== 2 || instr_pc !== e.pc || instr !== e.ins) begin
                err_count++;
                $display("FAIL halt_word[%0d]: cycles=%0d pc=%h instr=%h required 2 pc=%h instr=%h",
                         k, n, instr_pc, instr, e.pc, e.ins);
            end
            step();
        end
        cmp_count++;
        if (halted !== 1'b1 || instr_valid !== 1'b0 || retired_count !== 16'd8) begin
            err_count++;
            $display("FAIL halt_enter: h=%b v=%b cnt=%0d required h=1 v=0 cnt=8",
                     halted, instr_valid, retired_count);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            cmp_count++;
            if (halted !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 8'h07) begin
                err_count++;
                $display("FAIL halt_stay[%0d]: h=%b v=%b addr=%h required h=1 v=0 addr=07",
                         c, halted, instr_valid, imem_addr);
            end
        end
        sb.push_back({8'h00, mem[0]});
        branch_valid = 1'b1;
        branch_target = 8'h00;
        step();
        branch_valid = 1'b0;
        cmp_count++;
        if (halted !== 1'b0 || imem_addr !== 8'h00) begin
            err_count++;
            $display("FAIL halt_exit: h=%b addr=%h required h=0 addr=00", halted, imem_addr);
        end
        wait_valid(n);
        pop_exp(e);
        $display("txn restart pc=%h instr=%h", instr_pc, instr);
        cmp_count++;
        if (n !== 2 || instr_pc !== e.pc || instr !== e.ins) begin
            err_count++;
            $display("FAIL halt_restart: cycles=%0d pc=%h instr=%h required 2 pc=%h instr=%h",
                     n, instr_pc, instr, e.pc, e.ins);
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_branch();
        exp_t e;
        int   n;
        branch_valid = 1'b1;
        branch_target = 8'h05;
        step();
        branch_valid = 1'b0;
        cmp_count++;
        if (imem_addr !== 8'h05) begin
            err_count++;
            $display("FAIL branch_issue_addr: addr=%h required 05", imem_addr);
        end
        sb.push_back({8'h40, mem[8'h40]});
        instr_ready = 1'b1;
        enable = 1'b1;
        step();
        // DUT is now capturing address 0x05; redirect it away.
        branch_valid = 1'b1;
        branch_target = 8'h40;
        step();
        branch_valid = 1'b0;
        cmp_count++;
        if (instr_valid !== 1'b0 || imem_addr !== 8'h40) begin
            err_count++;
            $display("FAIL branch_capture: v=%b addr=%h required v=0 addr=40", instr_valid, imem_addr);
        end
        wait_valid(n);
        pop_exp(e);
        $display("txn branch pc=%h instr=%h", instr_pc, instr);
        cmp_count++;
        if (n !== 2 || instr_pc !== e.pc || instr !== e.ins) begin
            err_count++;
            $display("FAIL branch_word: cycles=%0d pc=%h instr=%h required 2 pc=%h instr=%h",
                     n, instr_pc, instr, e.pc, e.ins);
        end
        sb.push_back({8'h40, mem[8'h40]});
        branch_valid = 1'b1;
        branch_target = 8'h40;
        step();
        branch_valid = 1'b0;
        cmp_count++;
        if (retired_count !== 16'd10 || instr_valid !== 1'b0) begin
            err_count++;
            $display("FAIL branch_ready_count: cnt=%0d v=%b required cnt=10 v=0", retired_count, instr_valid);
        end
        wait_valid(n);
        pop_exp(e);
        $display("txn branch_ready pc=%h instr=%h", instr_pc, instr);
        cmp_count++;
        if (n !== 2 || instr_pc !== e.pc || instr !== e.ins) begin
            err_count++;
            $display("FAIL branch_ready_word: cycles=%0d pc=%h instr=%h required 2 pc=%h instr=%h",
                     n, instr_pc, instr, e.pc, e.ins);
        end
        enable = 1'b0;
        step();
        cmp_count++;
        if (retired_count !== 16'd11) begin
            err_count++;
            $display("FAIL branch_final_count: cnt=%0d required 11", retired_count);
        end
    endtask

    task automatic test_wrap_saturate();
        exp_t e;
        int   n;
        branch_valid = 1'b1;
        branch_target = 8'hFF;
        step();
        branch_valid = 1'b0;
        sb.push_back({8'hFF, mem[8'hFF]});
        sb.push_back({8'h00, mem[8'h00]});
        sb.push_back({8'h01, mem[8'h01]});
        force dut.retired_count_reg = 16'hFFFE;
        #1;
        release dut.retired_count_reg;
        instr_ready = 1'b1;
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid(n);
            pop_exp(e);
            $display("txn wrap pc=%h instr=%h", instr_pc, instr);
            cmp_count++;
            if (n !== 2 || instr_pc !== e.pc || instr !== e.ins) begin
                err_count++;
                $display("FAIL wrap_word[%0d]: cycles=%0d pc=%h instr=%h required 2 pc=%h instr=%h",
                         k, n, instr_pc, instr, e.pc, e.ins);
            end
            if (k == 2) enable = 1'b0;
            step();
        end
        cmp_count++;
        if (retired_count !== 16'hFFFF) begin
            err_count++;
            $display("FAIL count_saturate: cnt=%h required ffff", retired_count);
        end
    endtask

    task automatic test_reset_in_hold();
        exp_t e;
        int   n;
        sb.push_back({8'h02, mem[2]});
        instr_ready = 1'b0;
        enable = 1'b1;
        wait_valid(n);
        pop_exp(e);
        $display("txn pre_reset pc=%h instr=%h", instr_pc, instr);
        cmp_count++;
        if (n !== 2 || instr_pc !== e.pc || instr !== e.ins) begin
            err_count++;
            $display("FAIL pre_reset_word: cycles=%0d pc=%h instr=%h required 2 pc=%h instr=%h",
                     n, instr_pc, instr, e.pc, e.ins);
        end
        instr_ready = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        cmp_count++;
        if ({imem_addr, instr, instr_pc, instr_valid, halted, retired_count} !== 42'd0) begin
            err_count++;
            $display("FAIL async_reset: addr=%h instr=%h pc=%h v=%b h=%b cnt=%h required all zero",
                     imem_addr, instr, instr_pc, instr_valid, halted, retired_count);
        end
        step(); step();
        sb.push_back({8'h00, mem[0]});
        reset_n = 1'b1;
        wait_valid(n);
        pop_exp(e);
        $display("txn post_reset pc=%h instr=%h", instr_pc, instr);
        cmp_count++;
        if (n !== 3 || instr_pc !== e.pc || instr !== e.ins) begin
            err_count++;
            $display("FAIL post_reset_word: cycles=%0d pc=%h instr=%h required 3 pc=%h instr=%h",
                     n, instr_pc, instr, e.pc, e.ins);
        end
        enable = 1'b0;
        step();
        cmp_count++;
        if (retired_count !== 16'd1) begin
            err_count++;
            $display("FAIL post_reset_count: cnt=%0d required 1", retired_count);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + i[15:0];
        mem[0] = 16'h0401;
        mem[1] = 16'h0C01;
        mem[2] = 16'h4000;
        mem[7] = 16'h8000;
        test_reset();
        test_basic_fetch();
        test_hold_stall();
        test_halt();
        test_branch();
        test_wrap_saturate();
        test_reset_in_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
